// File: rtl/sin_lut_arb.sv
// Round-robin sequencer sharing one sine LUT between NUM_CH phase requesters.
// Ports: req/phi in, gnt out, lut_phi/lut_wav LUT side, wav_valid/wav_ch/wav result.
// Optional: SIN_LUT_ARB_QUARTER_WAVE_EN selects a quarter-wave table.
module sin_lut_arb #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 8,
  parameter int WIDTH  = 24,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
`ifdef SIN_LUT_ARB_QUARTER_WAVE_EN
  localparam int LA = ADDR_W - 2
`else
  localparam int LA = ADDR_W
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH*ADDR_W-1:0] phi,
  output logic [NUM_CH-1:0]        gnt,
  output logic [LA-1:0]            lut_phi,
  input  logic [WIDTH-1:0]         lut_wav,
  output logic                     wav_valid,
  output logic [CW-1:0]            wav_ch,
  output logic [WIDTH-1:0]         wav
);

  logic [CW-1:0]    ptr_q, ptr_d;
  logic             s1_valid_q, s1_valid_d;
  logic [CW-1:0]    s1_ch_q, s1_ch_d;
  logic [LA-1:0]    s1_addr_q, s1_addr_d;
  logic             wav_valid_q, wav_valid_d;
  logic [CW-1:0]    wav_ch_q, wav_ch_d;
  logic [WIDTH-1:0] wav_q, wav_d;
  logic [WIDTH-1:0] wav_proc;

  logic              found;
  logic [CW-1:0]     sel_ch;
  logic [ADDR_W-1:0] sel_phi;
  logic [LA-1:0]     addr_d;
  int                idx;

`ifdef SIN_LUT_ARB_QUARTER_WAVE_EN
  logic s1_neg_q, s1_neg_d;
  logic neg_d;
`endif

  // Search starts one past the last grant; first requester found wins.
  always_comb begin
    found  = 1'b0;
    sel_ch = '0;
    idx    = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && req[idx]) begin
        found  = 1'b1;
        sel_ch = CW'(idx);
      end
    end
    if (!rst) found = 1'b0;
    gnt     = found ? (NUM_CH'(1) << sel_ch) : '0;
    sel_phi = phi[sel_ch*ADDR_W +: ADDR_W];
  end

`ifdef SIN_LUT_ARB_QUARTER_WAVE_EN
  // Odd quadrants mirror the index; upper half-wave negates the sample.
  always_comb begin
    addr_d = sel_phi[ADDR_W-2] ? ~sel_phi[ADDR_W-3:0]
                               : sel_phi[ADDR_W-3:0];
    neg_d  = sel_phi[ADDR_W-1];
    s1_neg_d = found ? neg_d : s1_neg_q;
    wav_proc = s1_neg_q ? (-lut_wav) : lut_wav;
  end
`else
  always_comb begin
    addr_d   = sel_phi;
    wav_proc = lut_wav;
  end
`endif

  always_comb begin
    ptr_d       = found ? sel_ch : ptr_q;
    s1_valid_d  = found;
    s1_ch_d     = found ? sel_ch : s1_ch_q;
    s1_addr_d   = found ? addr_d : s1_addr_q;
    wav_valid_d = s1_valid_q;
    wav_ch_d    = s1_valid_q ? s1_ch_q : wav_ch_q;
    wav_d       = s1_valid_q ? wav_proc : wav_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_ch_q     <= '0;
      s1_addr_q   <= '0;
      wav_valid_q <= 1'b0;
      wav_ch_q    <= '0;
      wav_q       <= '0;
`ifdef SIN_LUT_ARB_QUARTER_WAVE_EN
      s1_neg_q    <= 1'b0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_ch_q     <= s1_ch_d;
      s1_addr_q   <= s1_addr_d;
      wav_valid_q <= wav_valid_d;
      wav_ch_q    <= wav_ch_d;
      wav_q       <= wav_d;
`ifdef SIN_LUT_ARB_QUARTER_WAVE_EN
      s1_neg_q    <= s1_neg_d;
`endif
    end
  end

  assign lut_phi   = s1_addr_q;
  assign wav_valid = wav_valid_q;
  assign wav_ch    = wav_ch_q;
  assign wav       = wav_q;

endmodule

// File: tb/tb_sin_lut_arb.sv
// Directed bench for sin_lut_arb with a mock LUT and an output scoreboard.
// Expected results are queued at grant time and compared when wav_valid is due.
module tb_sin_lut_arb;

`ifdef SIN_LUT_ARB_QUARTER_WAVE_EN
  localparam int LA = 6;
`else
  localparam int LA = 8;
`endif

  typedef struct {
    int          due;
    logic [1:0]  ch;
    logic [23:0] w;
  } sb_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    req = '0;
  logic [31:0]   phi = '0;
  logic [3:0]    gnt;
  logic [LA-1:0] lut_phi;
  logic [23:0]   lut_wav;
  logic          wav_valid;
  logic [1:0]    wav_ch;
  logic [23:0]   wav;

  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  sb_t sb[$];

  sin_lut_arb #(.NUM_CH(4), .ADDR_W(8), .WIDTH(24)) dut (
    .clk(clk), .rst(rst), .req(req), .phi(phi), .gnt(gnt),
    .lut_phi(lut_phi), .lut_wav(lut_wav), .wav_valid(wav_valid),
    .wav_ch(wav_ch), .wav(wav)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] lut_f(input logic [7:0] a);
    return {8'h01, a, ~a};
  endfunction

`ifdef SIN_LUT_ARB_QUARTER_WAVE_EN
  assign lut_wav = lut_f({2'b00, lut_phi});
`else
  assign lut_wav = lut_f(lut_phi);
`endif

  function automatic logic [23:0] exp_wav(input logic [1:0] ch);
    logic [7:0]  a;
    logic [5:0]  f;
    logic [23:0] v;
    a = phi[ch*8 +: 8];
`ifdef SIN_LUT_ARB_QUARTER_WAVE_EN
    f = a[6] ? ~a[5:0] : a[5:0];
    v = lut_f({2'b00, f});
    return a[7] ? (24'd0 - v) : v;
`else
    f = '0;
    v = lut_f(a);
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] egnt);
    sb_t e;
    bit  ev;
    @(negedge clk);
    ev = (sb.size() > 0) && (sb[0].due == cyc);
    chk("wav_valid", {31'd0, wav_valid}, {31'd0, ev});
    if (ev) begin
      e = sb.pop_front();
      if (wav_valid) begin
        chk("wav_ch", {30'd0, wav_ch}, {30'd0, e.ch});
        chk("wav", {8'd0, wav}, {8'd0, e.w});
      end
    end
    chk("gnt", {28'd0, gnt}, {28'd0, egnt});
    for (int k = 0; k < 4; k++) begin
      if (egnt[k]) begin
        e.due = cyc + 2;
        e.ch  = 2'(k);
        e.w   = exp_wav(2'(k));
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rst_step();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_valid", {31'd0, wav_valid}, 32'd0);
    chk("rst_wav", {8'd0, wav}, 32'd0);
    chk("rst_ch", {30'd0, wav_ch}, 32'd0);
    chk("rst_lut_phi", 32'(lut_phi), 32'd0);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // reset with all requests high
    req = 4'hF;
    phi = 32'hC0_80_40_10;
    rst_step();
    rst_step();
    rst = 1'b1;
    // full rotation, first grant goes to ch1
    for (int i = 0; i < 12; i++) step(4'b0001 << ((i + 1) % 4));
    req = 4'h0;
    step(4'h0);
    step(4'h0);
    // single requester ch2 at phase 0x40
    req = 4'b0100;
    phi = 32'h00_40_00_00;
    step(4'b0100);
    req = 4'h0;
`ifndef SIN_LUT_ARB_QUARTER_WAVE_EN
    chk("lut_phi_40", 32'(lut_phi), 32'h40);
`endif
    step(4'h0);
    step(4'h0);
    // ch0/ch3 contention from ptr=3
    phi = 32'h33_22_11_05;
    req = 4'b1000;
    step(4'b1000);
    req = 4'b1001;
    step(4'b0001);
    step(4'b1000);
    step(4'b0001);
    step(4'b1000);
    req = 4'h0;
    step(4'h0);
    step(4'h0);
    // single requester held high
    req = 4'b0010;
    step(4'b0010);
    step(4'b0010);
    step(4'b0010);
    req = 4'h0;
    step(4'h0);
    step(4'h0);
    // reset with lookups in flight
    req = 4'hF;
    step(4'b0100);
    step(4'b1000);
    rst_step();
    req = 4'h0;
    rst = 1'b1;
    step(4'h0);
    step(4'h0);
    step(4'h0);
    req = 4'hF;
    step(4'b0010);
    step(4'b0100);
    req = 4'h0;
    step(4'h0);
    step(4'h0);
`ifdef SIN_LUT_ARB_QUARTER_WAVE_EN
    req = 4'b0001;
    phi = 32'h00_00_00_40;
    step(4'b0001);
    chk("qw_lut_phi_40", 32'(lut_phi), 32'h3F);
    phi = 32'h00_00_00_C0;
    step(4'b0001);
    chk("qw_lut_phi_C0", 32'(lut_phi), 32'h3F);
    phi = 32'h00_00_00_80;
    step(4'b0001);
    chk("qw_lut_phi_80", 32'(lut_phi), 32'h00);
    req = 4'h0;
    step(4'h0);
    step(4'h0);
`endif
    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
